// File: rtl/gpr_exec_sequencer.sv
// Multi-cycle sequencer for the IR/GPR arithmetic datapath.
// Fetches 32-bit instructions over a req/rdy handshake, holds them in IR,
// walks FETCH -> DECODE -> EXEC -> WB and issues one-cycle write strobes
// to the GPR file and the SGPR. Halts on HALT or an undefined opcode.
module gpr_exec_sequencer #(
   parameter int PC_W       = 8,
   parameter int MUL_CYCLES = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_rdy,
   input  logic [31:0]     imem_data,
   output logic [31:0]     ir,
   output logic            gpr_we,
   output logic            sgpr_we,
   output logic            busy,
   output logic            halted,
   output logic            illegal,
   output logic [15:0]     retired
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [4:0] OP_MUL   = 5'b00100;
   localparam logic [4:0] OP_LAST  = 5'b00100;   // highest legal opcode
   localparam logic [4:0] OP_HALT  = 5'b11111;

   // Execute counter preload for mul; one EXEC cycle per count down to 0.
   localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
   localparam logic [PC_W-1:0] PC_ONE = 1;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [15:0]       retired_q, retired_d;
   logic              illegal_q, illegal_d;

   // Registered Moore outputs, loaded from the next state so they line up
   // with the state they describe.
   logic              req_q;
   logic              gpr_we_q;
   logic              sgpr_we_q;
   logic              busy_q;
   logic              halted_q;

   logic [4:0]        opcode;
   logic [4:0]        opcode_next;
   logic              op_halt;
   logic              op_legal;
   logic              op_mul;

   assign opcode      = ir_q[31:27];
   assign opcode_next = ir_d[31:27];
   assign op_halt     = (opcode == OP_HALT);
   assign op_legal    = (opcode <= OP_LAST);
   assign op_mul      = (opcode == OP_MUL);

   // Next-state and datapath-register update rules.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      cnt_d     = cnt_q;
      retired_d = retired_q;
      illegal_d = illegal_q;
      case (state_q)
         S_IDLE, S_HALT: begin
            // A new run always starts at address 0 with fresh status.
            if (start) begin
               state_d   = S_FETCH;
               pc_d      = '0;
               retired_d = '0;
               illegal_d = 1'b0;
            end
         end
         S_FETCH: begin
            // The request stays up until memory answers; IR only moves here.
            if (imem_rdy) begin
               ir_d    = imem_data;
               pc_d    = pc_q + PC_ONE;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (op_halt) begin
               state_d = S_HALT;
            end else if (!op_legal) begin
               illegal_d = 1'b1;
               state_d   = S_HALT;
            end else begin
               state_d = S_EXEC;
               cnt_d   = op_mul ? MUL_LOAD : 4'd0;
            end
         end
         S_EXEC: begin
            if (cnt_q == 4'd0) begin
               state_d = S_WB;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_WB: begin
            if (retired_q != 16'hFFFF) begin
               retired_d = retired_q + 16'd1;
            end
            state_d = S_FETCH;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, datapath registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         ir_q      <= '0;
         cnt_q     <= '0;
         retired_q <= '0;
         illegal_q <= 1'b0;
         req_q     <= 1'b0;
         gpr_we_q  <= 1'b0;
         sgpr_we_q <= 1'b0;
         busy_q    <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         cnt_q     <= cnt_d;
         retired_q <= retired_d;
         illegal_q <= illegal_d;
         req_q     <= (state_d == S_FETCH);
         gpr_we_q  <= (state_d == S_WB);
         sgpr_we_q <= (state_d == S_WB) && (opcode_next == OP_MUL);
         busy_q    <= (state_d == S_FETCH) || (state_d == S_DECODE) ||
                      (state_d == S_EXEC)  || (state_d == S_WB);
         halted_q  <= (state_d == S_HALT);
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = pc_q;
   assign ir        = ir_q;
   assign gpr_we    = gpr_we_q;
   assign sgpr_we   = sgpr_we_q;
   assign busy      = busy_q;
   assign halted    = halted_q;
   assign illegal   = illegal_q;
   assign retired   = retired_q;

endmodule

// File: tb/tb_gpr_exec_sequencer.sv
// Self-checking bench for gpr_exec_sequencer. A transaction-level model
// expands each program into the expected per-cycle output trace, which is
// compared against the DUT every cycle; literal checks pin key timings.
module tb_gpr_exec_sequencer;

   localparam int PC_W       = 8;
   localparam int MUL_CYCLES = 3;
   localparam int MAXT       = 2048;

   localparam logic [31:0] I_ADD  = 32'h1080_0005;
   localparam logic [31:0] I_ADD2 = 32'h1084_0003;
   localparam logic [31:0] I_MUL  = 32'h2000_0007;
   localparam logic [31:0] I_HALT = 32'hF800_0000;
   localparam logic [31:0] I_ILL  = 32'h5000_0000;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            imem_rdy = 1'b0;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic [31:0]     imem_data;
   logic [31:0]     ir;
   logic            gpr_we;
   logic            sgpr_we;
   logic            busy;
   logic            halted;
   logic            illegal;
   logic [15:0]     retired;

   typedef struct packed {
      logic        req;
      logic [7:0]  addr;
      logic [31:0] ir;
      logic        gwe;
      logic        swe;
      logic        busy;
      logic        halted;
      logic        ill;
      logic [15:0] ret;
   } obs_t;

   logic [31:0] mem [256];
   obs_t        exp_q [MAXT+1];
   obs_t        got_q [MAXT+1];
   bit          rdy_seq [MAXT+1];
   logic [31:0] m_ir;
   int          pass_cnt = 0;
   int          check_cnt = 0;

   always #5 clk = ~clk;

   assign imem_data = mem[imem_addr];

   gpr_exec_sequencer #(
      .PC_W       (PC_W),
      .MUL_CYCLES (MUL_CYCLES)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_rdy  (imem_rdy),
      .imem_data (imem_data),
      .ir        (ir),
      .gpr_we    (gpr_we),
      .sgpr_we   (sgpr_we),
      .busy      (busy),
      .halted    (halted),
      .illegal   (illegal),
      .retired   (retired)
   );

   function automatic obs_t sample();
      obs_t s;
      s.req = imem_req; s.addr = imem_addr; s.ir = ir; s.gwe = gpr_we;
      s.swe = sgpr_we; s.busy = busy; s.halted = halted; s.ill = illegal;
      s.ret = retired;
      return s;
   endfunction

   function automatic obs_t mk(logic req, logic [7:0] addr, logic [31:0] irv,
                               logic gwe, logic swe, logic bsy, logic hlt,
                               logic ill, logic [15:0] ret);
      obs_t s;
      s.req = req; s.addr = addr; s.ir = irv; s.gwe = gwe; s.swe = swe;
      s.busy = bsy; s.halted = hlt; s.ill = ill; s.ret = ret;
      return s;
   endfunction

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
      check_cnt++;
      if (got === want) pass_cnt++;
      else $display("FAIL %s: got %0h want %0h", name, got, want);
   endtask

   task automatic put(input int t, input int lim, input obs_t v);
      if (t <= lim) exp_q[t] = v;
   endtask

   // Expand the program in mem[] and the ready pattern into the expected
   // per-cycle trace. Cycle 1 is the first cycle after start is sampled.
   task automatic build_model(input int lim, output int n);
      int         t;
      logic [7:0] pc;
      logic [15:0] ret;
      logic       ill;
      logic [4:0] op;
      bit         done;
      t = 1; pc = 8'd0; ret = 16'd0; ill = 1'b0; done = 1'b0; n = lim;
      while (t <= lim && !done) begin
         while (t <= lim && !rdy_seq[t]) begin
            put(t, lim, mk(1, pc, m_ir, 0, 0, 1, 0, ill, ret)); t++;
         end
         put(t, lim, mk(1, pc, m_ir, 0, 0, 1, 0, ill, ret)); t++;
         m_ir = mem[pc];
         pc   = pc + 8'd1;
         put(t, lim, mk(0, pc, m_ir, 0, 0, 1, 0, ill, ret)); t++;
         op = m_ir[31:27];
         if (op == 5'h1F || op > 5'd4) begin
            if (op != 5'h1F) ill = 1'b1;
            repeat (3) begin
               put(t, lim, mk(0, pc, m_ir, 0, 0, 0, 1, ill, ret)); t++;
            end
            n = (t - 1 < lim) ? t - 1 : lim;
            done = 1'b1;
         end else begin
            repeat ((op == 5'd4) ? MUL_CYCLES : 1) begin
               put(t, lim, mk(0, pc, m_ir, 0, 0, 1, 0, ill, ret)); t++;
            end
            put(t, lim, mk(0, pc, m_ir, 1, op == 5'd4, 1, 0, ill, ret)); t++;
            if (ret != 16'hFFFF) ret = ret + 16'd1;
         end
      end
   endtask

   // Called just after a rising edge with the DUT in IDLE or HALT.
   task automatic run(input string name, input int lim, output int n);
      int bad;
      build_model(lim, n);
      bad = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int t = 1; t <= n; t++) begin
         imem_rdy = rdy_seq[t];
         @(negedge clk);
         got_q[t] = sample();
         check_cnt++;
         if (got_q[t] === exp_q[t]) pass_cnt++;
         else begin
            bad++;
            $display("FAIL %s cycle %0d: got %h want %h", name, t, got_q[t], exp_q[t]);
         end
         @(posedge clk); #1;
      end
      imem_rdy = 1'b0;
      $display("run %s: %0d cycles compared, %0d wrong", name, n, bad);
   endtask

   task automatic fill_rdy(input int pct_low);
      for (int i = 0; i <= MAXT; i++)
         rdy_seq[i] = ($urandom_range(0, 99) >= pct_low);
   endtask

   task automatic fill_mem(input int max_op);
      for (int i = 0; i < 256; i++)
         mem[i] = {5'($urandom_range(0, max_op)), 27'($urandom)};
   endtask

   initial begin
      int n;
      int cnt;
      m_ir = 32'd0;
      for (int i = 0; i < 256; i++) mem[i] = I_HALT;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", 128'(sample()), 128'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_reset", 128'(sample()), 128'd0);

      // add then HALT, memory always ready
      mem[0] = I_ADD; mem[1] = I_HALT;
      fill_rdy(0);
      run("add_halt", MAXT, n);
      chk("add_gwe_c3", 128'(got_q[3].gwe), 128'd0);
      chk("add_gwe_c4", 128'(got_q[4].gwe), 128'd1);
      chk("add_gwe_c5", 128'(got_q[5].gwe), 128'd0);
      chk("add_model_gwe_c4", 128'(exp_q[4].gwe), 128'd1);
      chk("add_halted_c6", 128'(got_q[6].halted), 128'd0);
      chk("add_halted_c7", 128'(got_q[7].halted), 128'd1);
      chk("add_retired", 128'(got_q[n].ret), 128'd1);
      chk("add_ir", 128'(got_q[2].ir), 128'(I_ADD));

      // mul then HALT
      mem[0] = I_MUL; mem[1] = I_HALT;
      run("mul_halt", MAXT, n);
      chk("mul_exec_c5_busy", 128'({got_q[5].busy, got_q[5].req, got_q[5].gwe}), 128'b100);
      chk("mul_we_c6", 128'({got_q[6].gwe, got_q[6].swe}), 128'b11);
      chk("mul_we_c5", 128'({got_q[5].gwe, got_q[5].swe}), 128'b00);
      chk("mul_req_c6", 128'(got_q[6].req), 128'd0);
      chk("mul_req_c7", 128'(got_q[7].req), 128'd1);
      chk("mul_model_swe_c6", 128'(exp_q[6].swe), 128'd1);

      // second fetch stalled for 5 cycles
      mem[0] = I_ADD; mem[1] = I_ADD2; mem[2] = I_HALT;
      fill_rdy(0);
      for (int i = 5; i <= 9; i++) rdy_seq[i] = 1'b0;
      run("stall", MAXT, n);
      chk("stall_req_c9", 128'({got_q[9].req, got_q[9].addr}), 128'({1'b1, 8'd1}));
      chk("stall_ir_c10", 128'(got_q[10].ir), 128'(I_ADD));
      chk("stall_ir_c11", 128'(got_q[11].ir), 128'(I_ADD2));
      chk("stall_gwe_c13", 128'(got_q[13].gwe), 128'd1);
      chk("stall_gwe_c8", 128'(got_q[8].gwe), 128'd0);
      fill_rdy(0);

      // illegal opcode 01010
      mem[0] = I_ILL;
      run("illegal", MAXT, n);
      chk("ill_c3", 128'({got_q[3].halted, got_q[3].ill}), 128'b11);
      cnt = 0;
      for (int t = 1; t <= n; t++) if (got_q[t].gwe || got_q[t].swe) cnt++;
      chk("ill_no_strobes", 128'(cnt), 128'd0);
      chk("ill_retired", 128'(got_q[n].ret), 128'd0);

      // restart from HALT clears illegal and refetches address 0
      mem[0] = I_ADD; mem[1] = I_HALT;
      run("restart", MAXT, n);
      chk("restart_c1", 128'({got_q[1].req, got_q[1].addr, got_q[1].ill}), 128'({1'b1, 8'd0, 1'b0}));

      // randomized programs with random memory latency
      for (int r = 0; r < 4; r++) begin
         fill_mem(4);
         mem[$urandom_range(5, 30)] = I_HALT;
         fill_rdy(30);
         run($sformatf("random%0d", r), MAXT, n);
      end
      fill_mem(31);
      mem[40] = I_HALT;
      fill_rdy(20);
      run("random_anyop", MAXT, n);

      // PC wrap: no HALT, non-mul ops, memory always ready
      fill_mem(3);
      fill_rdy(0);
      run("wrap", 1100, n);
      chk("wrap_addr255", 128'({got_q[1021].req, got_q[1021].addr}), 128'({1'b1, 8'd255}));
      chk("wrap_addr0", 128'({got_q[1025].req, got_q[1025].addr}), 128'({1'b1, 8'd0}));
      chk("wrap_retired", 128'(got_q[1100].ret), 128'd274);

      // asynchronous reset during mul EXEC
      rst_n = 1'b0;
      m_ir  = 32'd0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      mem[0] = I_MUL; mem[1] = I_HALT;
      imem_rdy = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pre_exec", 128'({busy, imem_req, gpr_we}), 128'b100);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_immediate", 128'(sample()), 128'd0);
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (gpr_we || sgpr_we) cnt++;
      end
      chk("rst_no_strobe", 128'(cnt), 128'd0);
      #1;
      rst_n = 1'b1;
      cnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (busy || halted || imem_req || gpr_we || sgpr_we) cnt++;
      end
      chk("rst_idle_after", 128'(cnt), 128'd0);
      @(posedge clk); #1;
      fill_rdy(0);
      run("after_reset", MAXT, n);
      chk("after_reset_swe_c6", 128'(got_q[6].swe), 128'd1);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
